// File: rtl/mult32_seq_ctrl.sv
// Sequential 32x32 unsigned shift-and-add multiplier: one AND gating stage and one
// 33-bit adder reused over 32 iterations, with a start/busy/done handshake.
module mult32_seq_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [63:0] product
);

    // Handshake: start is sampled only in IDLE; the accepting edge captures a/b.
    // busy is high for the 32 RUN cycles, then done pulses for exactly one cycle
    // with product already updated. start/a/b are ignored outside IDLE.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] mcand_q, mcand_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [63:0] res_q, res_d;

    logic [31:0] partial;
    logic [32:0] sum;

    assign partial = mcand_q & {32{lo_q[0]}};
    assign sum     = {1'b0, hi_q} + {1'b0, partial};

    always_comb begin
        state_d = state_q;
        mcand_d = mcand_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    mcand_d = a;
                    lo_d    = b;
                    hi_d    = 32'd0;
                    cnt_d   = 5'd0;
                    state_d = RUN;
                end
            end
            RUN: begin
                // The adder carry lands in hi[31], so no product bit is ever dropped.
                hi_d  = sum[32:1];
                lo_d  = {sum[0], lo_q[31:1]};
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    res_d   = {sum[32:1], sum[0], lo_q[31:1]};
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            mcand_q <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            cnt_q   <= 5'd0;
            res_q   <= 64'd0;
        end else begin
            state_q <= state_d;
            mcand_q <= mcand_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
        end
    end

    assign busy    = (state_q == RUN);
    assign done    = (state_q == DONE);
    assign product = res_q;

endmodule

// File: tb/tb_mult32_seq_ctrl.sv
// Directed plus random checks of mult32_seq_ctrl against a plain a*b reference.
module tb_mult32_seq_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [63:0] product;

  int errors;
  int checks;
  int cycle;
  int done_cycle;
  int prev_done_cycle;
  logic [63:0] exp_q[$];

  mult32_seq_ctrl dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cycle++;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // reference model: the product is simply the 64-bit unsigned a*b
  function automatic logic [63:0] ref_mul(input logic [31:0] av, input logic [31:0] bv);
    logic [63:0] wa;
    logic [63:0] wb;
    wa = {32'd0, av};
    wb = {32'd0, bv};
    return wa * wb;
  endfunction

  // Called in the cycle after the accepting edge; runs until done is seen.
  task automatic finish_op(input string tag, input int pulse_at, input bit hold);
    int n;
    int bc;
    int both;
    logic [63:0] exp;
    n = 0;
    bc = 0;
    both = 0;
    while (!done && n < 40) begin
      if (busy) bc++;
      if (!hold) begin
        if (n == pulse_at) begin
          start = 1'b1;
          a = 32'd9;
          b = 32'd9;
        end else begin
          start = 1'b0;
        end
      end
      tick();
      n++;
      if (busy && done) both++;
    end
    check({tag, "_busy_cycles"}, 64'(bc), 64'd32);
    check({tag, "_latency"}, 64'(n), 64'd32);
    check({tag, "_done"}, {63'd0, done}, 64'd1);
    check({tag, "_busy_done_overlap"}, 64'(both), 64'd0);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hDEAD;
    check({tag, "_product"}, product, exp);
    prev_done_cycle = done_cycle;
    done_cycle = cycle;
  endtask

  task automatic do_mult(input string tag, input logic [31:0] av, input logic [31:0] bv);
    a = av;
    b = bv;
    start = 1'b1;
    exp_q.push_back(ref_mul(av, bv));
    tick();
    finish_op(tag, -1, 1'b0);
    tick();
    check({tag, "_done_pulse_end"}, {63'd0, done}, 64'd0);
    check({tag, "_idle_busy"}, {63'd0, busy}, 64'd0);
  endtask

  initial begin
    int dcount;
    logic [63:0] held;
    errors = 0;
    checks = 0;
    cycle = 0;
    done_cycle = 0;
    prev_done_cycle = 0;
    rst_n = 1'b0;
    start = 1'b0;
    a = 32'd0;
    b = 32'd0;
    tick();
    tick();
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_done", {63'd0, done}, 64'd0);
    check("reset_product", product, 64'd0);
    rst_n = 1'b1;

    do_mult("basic", 32'd3, 32'd5);
    check("basic_value", product, 64'h0000_0000_0000_000F);
    do_mult("max", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("max_value", product, 64'hFFFF_FFFE_0000_0001);
    do_mult("msb_x2", 32'h8000_0000, 32'd2);
    check("msb_x2_value", product, 64'h0000_0001_0000_0000);

    // zero result, then hold under toggling inputs
    do_mult("zero", 32'd0, 32'h1234_5678);
    dcount = 0;
    for (int i = 0; i < 100; i++) begin
      a = $urandom;
      b = $urandom;
      tick();
      if (done || busy || product !== 64'd0) dcount++;
    end
    check("zero_hold", 64'(dcount), 64'd0);

    // start pulses in RUN and DONE must be ignored
    a = 32'd7;
    b = 32'd6;
    start = 1'b1;
    exp_q.push_back(ref_mul(32'd7, 32'd6));
    tick();
    finish_op("ignore", 10, 1'b0);
    start = 1'b1;
    a = 32'd9;
    b = 32'd9;
    tick();
    start = 1'b0;
    dcount = 0;
    for (int i = 0; i < 6; i++) begin
      if (busy || done) dcount++;
      tick();
    end
    check("ignore_no_restart", 64'(dcount), 64'd0);
    check("ignore_value", product, 64'd42);

    // asynchronous reset in the middle of an operation
    a = 32'd100;
    b = 32'd100;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (16) tick();
    check("midrst_pre_busy", {63'd0, busy}, 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", {63'd0, busy}, 64'd0);
    check("midrst_done", {63'd0, done}, 64'd0);
    check("midrst_product", product, 64'd0);
    tick();
    tick();
    rst_n = 1'b1;
    dcount = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done || busy) dcount++;
    end
    check("midrst_no_done", 64'(dcount), 64'd0);
    do_mult("after_rst", 32'd12, 32'd12);
    check("after_rst_value", product, 64'd144);

    // back-to-back with start held high
    a = 32'h0001_0000;
    b = 32'h0001_0000;
    start = 1'b1;
    exp_q.push_back(ref_mul(32'h0001_0000, 32'h0001_0000));
    tick();
    finish_op("b2b_first", -1, 1'b1);
    check("b2b_first_value", product, 64'h0000_0001_0000_0000);
    a = 32'd2;
    b = 32'd3;
    exp_q.push_back(ref_mul(32'd2, 32'd3));
    tick();
    check("b2b_gap_done", {63'd0, done}, 64'd0);
    tick();
    finish_op("b2b_second", -1, 1'b1);
    check("b2b_second_value", product, 64'd6);
    check("b2b_spacing", 64'(done_cycle - prev_done_cycle), 64'd34);
    start = 1'b0;
    tick();
    tick();

    // random operands against the reference
    for (int i = 0; i < 8; i++) begin
      logic [31:0] ra;
      logic [31:0] rb;
      ra = $urandom;
      rb = (i < 2) ? 32'hFFFF_FFFF : $urandom;
      do_mult("rand", ra, rb);
      held = product;
      repeat ($urandom_range(0, 5)) begin
        a = $urandom;
        b = $urandom;
        tick();
      end
      check("rand_hold", product, held);
    end

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
